// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_scan_ctrl : 4x4 keypad row scanner, key hold/release and hex decode
// Revision 1.0
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
   parameter int SETTLE_CYCLES  = 300,
   parameter int RELEASE_CYCLES = 30000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic       key_pressed,
   output logic [3:0] row_idx,
   output logic [3:0] col_idx,
   input  logic       key_valid,
   input  logic [3:0] key_row,
   input  logic [3:0] key_col,
   output logic       new_key,
   output logic [3:0] key_code,
   output logic [3:0] digit_hi,
   output logic [3:0] digit_lo
);

   localparam int c_set_w = $clog2(SETTLE_CYCLES + 1);
   localparam int c_rel_w = $clog2(RELEASE_CYCLES + 1);
   localparam logic [c_set_w-1:0] c_set_last = c_set_w'(SETTLE_CYCLES - 1);
   localparam logic [c_rel_w-1:0] c_rel_last = c_rel_w'(RELEASE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [1:0]         r_row, w_row_nxt;
   logic [c_set_w-1:0] r_set_cnt, w_set_nxt;
   logic [c_rel_w-1:0] r_rel_cnt, w_rel_nxt;
   logic [3:0]         r_lat_row, w_lat_row_nxt;
   logic [3:0]         r_lat_col, w_lat_col_nxt;
   logic [3:0]         r_col_sync1, r_col_sync2;
   logic               r_kv_prev;

   logic [3:0] w_col_s;
   logic [3:0] w_row_drive;
   logic       w_hold;
   logic       w_accept;
   logic [3:0] w_code;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] onehot_bin(input logic [3:0] v);
      case (v)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] hex_of(input logic [1:0] rb, input logic [1:0] cb);
      case ({rb, cb})
         4'h0: return 4'h1;   4'h1: return 4'h2;   4'h2: return 4'h3;   4'h3: return 4'hA;
         4'h4: return 4'h4;   4'h5: return 4'h5;   4'h6: return 4'h6;   4'h7: return 4'hB;
         4'h8: return 4'h7;   4'h9: return 4'h8;   4'hA: return 4'h9;   4'hB: return 4'hC;
         4'hC: return 4'hE;   4'hD: return 4'h0;   4'hE: return 4'hF;   default: return 4'hD;
      endcase
   endfunction

   assign w_col_s     = ~r_col_sync2;
   assign w_row_drive = 4'b0001 << r_row;
   assign w_hold      = (r_state == ST_HOLD);
   assign row_n       = w_hold ? ~r_lat_row : ~w_row_drive;
   assign row_idx     = w_hold ? r_lat_row : 4'd0;
   assign col_idx     = w_hold ? r_lat_col : 4'd0;
   assign key_pressed = w_hold && ((w_col_s & r_lat_col) != 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_SETTLE;
         r_row       <= 2'd0;
         r_set_cnt   <= '0;
         r_rel_cnt   <= '0;
         r_lat_row   <= 4'd0;
         r_lat_col   <= 4'd0;
         r_col_sync1 <= 4'd0;
         r_col_sync2 <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_row       <= w_row_nxt;
         r_set_cnt   <= w_set_nxt;
         r_rel_cnt   <= w_rel_nxt;
         r_lat_row   <= w_lat_row_nxt;
         r_lat_col   <= w_lat_col_nxt;
         r_col_sync1 <= col_n;
         r_col_sync2 <= r_col_sync1;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_row_nxt     = r_row;
      w_set_nxt     = r_set_cnt;
      w_rel_nxt     = r_rel_cnt;
      w_lat_row_nxt = r_lat_row;
      w_lat_col_nxt = r_lat_col;
      case (r_state)
         ST_SETTLE: begin
            if (r_set_cnt == c_set_last) begin
               w_set_nxt   = '0;
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_set_nxt = r_set_cnt + 1'b1;
            end
         end
         ST_SAMPLE: begin
            // Zero or multiple columns is treated as ghost/chord: move on.
            if (is_onehot(w_col_s)) begin
               w_lat_row_nxt = w_row_drive;
               w_lat_col_nxt = w_col_s;
               w_rel_nxt     = '0;
               w_state_nxt   = ST_HOLD;
            end else begin
               w_row_nxt   = r_row + 2'd1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_HOLD: begin
            if (key_pressed) begin
               w_rel_nxt = '0;
            end else if (r_rel_cnt == c_rel_last) begin
               w_rel_nxt     = '0;
               w_row_nxt     = 2'd0;
               w_lat_row_nxt = 4'd0;
               w_lat_col_nxt = 4'd0;
               w_state_nxt   = ST_SETTLE;
            end else begin
               w_rel_nxt = r_rel_cnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_SETTLE;
      endcase
   end

   assign w_accept = key_valid && !r_kv_prev && is_onehot(key_row) && is_onehot(key_col);
   assign w_code   = hex_of(onehot_bin(key_row), onehot_bin(key_col));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_kv_prev <= 1'b0;
         new_key   <= 1'b0;
         key_code  <= 4'd0;
         digit_hi  <= 4'd0;
         digit_lo  <= 4'd0;
      end else begin
         r_kv_prev <= key_valid;
         new_key   <= w_accept;
         if (w_accept) begin
            key_code <= w_code;
            digit_hi <= digit_lo;
            digit_lo <= w_code;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl : keypad matrix model, debouncer stub and code scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

   localparam int SETTLE  = 4;
   localparam int RELEASE = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic       key_pressed;
   logic [3:0] row_idx, col_idx;
   logic       key_valid;
   logic [3:0] key_row, key_col;
   logic       new_key;
   logic [3:0] key_code, digit_hi, digit_lo;

   keypad_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .RELEASE_CYCLES(RELEASE)) dut (
      .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
      .key_pressed(key_pressed), .row_idx(row_idx), .col_idx(col_idx),
      .key_valid(key_valid), .key_row(key_row), .key_col(key_col),
      .new_key(new_key), .key_code(key_code), .digit_hi(digit_hi), .digit_lo(digit_lo)
   );

   always #5 clk = ~clk;

   // Pressed-key matrix, bit row*4+col; a pressed key pulls its column low when its row is driven.
   logic [15:0] keys;
   logic [3:0]  col_acc;
   always_comb begin
      col_acc = 4'd0;
      for (int r = 0; r < 4; r++)
         if (!row_n[r]) col_acc = col_acc | keys[r*4 +: 4];
   end
   assign col_n = ~col_acc;

   logic [3:0] c_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;
   int         exp_pulses = 0;
   logic [3:0] exp_q [$];
   logic [3:0] model_lo = 4'd0;
   logic [3:0] mon_code;
   logic [3:0] exp_row;
   int         saw_hold;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         model_lo = 4'd0;
      end else if (new_key) begin
         pulses++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_new_key", 16'd1, 16'd0);
         end else begin
            mon_code = exp_q.pop_front();
            check_val("sb_key_code", {12'd0, key_code}, {12'd0, mon_code});
            check_val("sb_digit_lo", {12'd0, digit_lo}, {12'd0, mon_code});
            check_val("sb_digit_hi", {12'd0, digit_hi}, {12'd0, model_lo});
            model_lo = mon_code;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_hold(input string tag);
      int n = 0;
      while (row_idx == 4'd0 && n < 100) begin
         tick(1);
         n++;
      end
      check_val(tag, {15'd0, row_idx != 4'd0}, 16'd1);
   endtask

   task automatic wait_release(input string tag);
      int n = 0;
      while (row_idx != 4'd0 && n < 100) begin
         tick(1);
         n++;
      end
      check_val(tag, {12'd0, row_n}, 16'h000E);
   endtask

   task automatic accept(input int row, input int col, input int hold);
      key_row   = 4'b0001 << row;
      key_col   = 4'b0001 << col;
      key_valid = 1'b1;
      exp_q.push_back(c_map[row*4 + col]);
      exp_pulses++;
      tick(hold);
      key_valid = 1'b0;
      key_row   = 4'd0;
      key_col   = 4'd0;
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; keys = 16'd0; key_valid = 1'b0; key_row = 4'd0; key_col = 4'd0;
      tick(3);
      check_val("rst_row_n", {12'd0, row_n}, 16'h000E);
      check_val("rst_idx", {7'd0, key_pressed, row_idx, col_idx}, 16'd0);
      check_val("rst_regs", {3'd0, new_key, key_code, digit_hi, digit_lo}, 16'd0);
      rst = 1'b0;

      // Idle sweep: each row driven for SETTLE+1 cycles.
      for (int k = 0; k <= 20; k++) begin
         exp_row = ~(4'b0001 << ((k / (SETTLE + 1)) % 4));
         check_val("scan_row_n", {12'd0, row_n}, {12'd0, exp_row});
         check_val("scan_idle_idx", {7'd0, key_pressed, row_idx, col_idx}, 16'd0);
         tick(1);
      end

      // Key "6"
      keys[1*4 + 2] = 1'b1;
      wait_hold("hold6_timeout");
      check_val("hold6_row_n", {12'd0, row_n}, 16'h000D);
      check_val("hold6_idx", {7'd0, key_pressed, row_idx, col_idx}, {7'd0, 1'b1, 4'b0010, 4'b0100});
      tick(2);
      accept(1, 2, 3);
      check_val("code6", {12'd0, key_code}, 16'h0006);
      keys = 16'd0;
      wait_release("rel6_row_n");

      // "1" then "D", key_valid held long on the second
      keys[0] = 1'b1;
      wait_hold("hold1_timeout");
      accept(0, 0, 3);
      keys = 16'd0;
      wait_release("rel1_row_n");
      keys[15] = 1'b1;
      wait_hold("holdD_timeout");
      check_val("holdD_idx", {8'd0, row_idx, col_idx}, {8'd0, 4'b1000, 4'b1000});
      accept(3, 3, 100);
      check_val("digits_1D", {8'd0, digit_hi, digit_lo}, 16'h001D);
      keys = 16'd0;
      wait_release("relD_row_n");

      // Rising key_valid with a non-one-hot row is dropped
      key_row = 4'b0011; key_col = 4'b0100; key_valid = 1'b1;
      tick(3);
      key_valid = 1'b0; key_row = 4'd0; key_col = 4'd0;
      tick(1);
      check_val("drop_key_code", {12'd0, key_code}, 16'h000D);

      // Bounce in HOLD on key "5", then exact release timing
      keys[1*4 + 1] = 1'b1;
      wait_hold("hold5_timeout");
      tick(2);
      keys = 16'd0;
      tick(5);
      keys[1*4 + 1] = 1'b1;
      tick(4);
      check_val("bounce_idx", {7'd0, key_pressed, row_idx, col_idx}, {7'd0, 1'b1, 4'b0010, 4'b0010});
      check_val("bounce_row_n", {12'd0, row_n}, 16'h000D);
      keys = 16'd0;
      tick(9);
      check_val("rel_early", {12'd0, row_idx}, 16'h0002);
      tick(1);
      check_val("rel_exact_idx", {12'd0, row_idx}, 16'd0);
      check_val("rel_exact_row_n", {12'd0, row_n}, 16'h000E);

      // Chord on row 2 (cols 0 and 3) is rejected
      keys[2*4 + 0] = 1'b1;
      keys[2*4 + 3] = 1'b1;
      saw_hold = 0;
      for (int k = 0; k < 45; k++) begin
         if (row_idx != 4'd0) saw_hold = 1;
         tick(1);
      end
      check_val("chord_no_hold", saw_hold[15:0], 16'd0);
      keys = 16'd0;
      tick(12);

      // Hold "7", second key on row 3 ignored
      keys[2*4 + 0] = 1'b1;
      wait_hold("hold7_timeout");
      check_val("hold7_idx", {8'd0, row_idx, col_idx}, {8'd0, 4'b0100, 4'b0001});
      keys[3*4 + 1] = 1'b1;
      tick(20);
      check_val("hold7_second_idx", {8'd0, row_idx, col_idx}, {8'd0, 4'b0100, 4'b0001});
      check_val("hold7_row_n", {12'd0, row_n}, 16'h000B);
      keys = 16'd0;
      wait_release("rel7_row_n");

      // Reset mid-HOLD coincident with a key_valid rise
      keys[1*4 + 2] = 1'b1;
      wait_hold("hold_rst_timeout");
      tick(1);
      rst = 1'b1; key_valid = 1'b1; key_row = 4'b0010; key_col = 4'b0100;
      tick(1);
      check_val("rst_hold_row_n", {12'd0, row_n}, 16'h000E);
      check_val("rst_hold_idx", {7'd0, key_pressed, row_idx, col_idx}, 16'd0);
      check_val("rst_hold_regs", {3'd0, new_key, key_code, digit_hi, digit_lo}, 16'd0);
      key_valid = 1'b0; key_row = 4'd0; key_col = 4'd0;
      tick(1);
      rst = 1'b0;
      keys = 16'd0;
      tick(30);

      check_val("pulse_count", pulses[15:0], exp_pulses[15:0]);
      check_val("queue_empty", exp_q.size(), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
